// File: rtl/uart_rx_fifo_if.sv
// Bus-side interface of uart_rx_fifo: FIFO pop/clear controls from the
// register block and the head-entry/status outputs of the receiver.
// master = bus/register side, slave = receiver.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                 pop_i;
    logic                 clear_overrun_i;
    logic [DATA_BITS-1:0] data_o;
    logic                 ready_o;
    logic                 parity_error_o;
    logic                 framing_error_o;
    logic [CW-1:0]        count_o;
    logic                 overrun_o;

    modport master (
        output pop_i, clear_overrun_i,
        input  data_o, ready_o, parity_error_o, framing_error_o, count_o, overrun_o
    );

    modport slave (
        input  pop_i, clear_overrun_i,
        output data_o, ready_o, parity_error_o, framing_error_o, count_o, overrun_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with first-word-fall-through receive FIFO.
// Each FIFO entry holds {framing_err, parity_err, data}.
// Optional macro UART_RX_INPUT_SYNC_EN: adds a two-flop synchroniser on
// serial_i (reset to idle-high), delaying every sample point by 2 cycles.
module uart_rx_fifo #(
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int DIVIDER_WIDTH = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     serial_i,
    input  logic [DIVIDER_WIDTH-1:0] clock_divider_i,
    input  logic                     parity_bit_i,
    input  logic                     parity_even_i,
    input  logic                     two_stop_bits_i,
    uart_rx_fifo_if.slave            bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity error for a received word: data XOR parity bit must be 0 for
    // even parity and 1 for odd parity.
    function automatic logic parity_err_f(input logic [DATA_BITS-1:0] data,
                                          input logic pbit,
                                          input logic even);
        return (((^data) ^ pbit) != ~even);
    endfunction

    logic serial_s;

`ifdef UART_RX_INPUT_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchroniser for the asynchronous pad input, idle-high at reset.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_i};
        end
    end

    assign serial_s = sync_q[1];
`else
    assign serial_s = serial_i;
`endif

    // Frame-level state, all latched at start detection
    state_t                   state_q;
    logic [DIVIDER_WIDTH-1:0] timer_q;
    logic [DIVIDER_WIDTH-1:0] div_q;
    logic                     par_en_q;
    logic                     par_even_q;
    logic                     two_stop_q;
    logic [3:0]               bit_cnt_q;
    logic                     stop_cnt_q;
    logic                     ferr_q;
    logic                     par_val_q;
    logic [DATA_BITS-1:0]     shift_q;

    // Timing and push decode
    logic [DIVIDER_WIDTH-1:0] half_s;
    logic [DIVIDER_WIDTH-1:0] div_eff_s;
    logic                     tick_s;
    logic                     mid_s;
    logic                     last_stop_s;
    logic                     push_s;
    logic [EW-1:0]            entry_s;

    assign div_eff_s   = (clock_divider_i < DIVIDER_WIDTH'(2)) ? DIVIDER_WIDTH'(2) : clock_divider_i;
    assign half_s      = div_q >> 1;
    assign tick_s      = (timer_q == div_q - DIVIDER_WIDTH'(1));
    assign mid_s       = (timer_q == half_s - DIVIDER_WIDTH'(1));
    assign last_stop_s = !two_stop_q || stop_cnt_q;
    assign push_s      = (state_q == S_STOP) && tick_s && last_stop_s;
    assign entry_s     = {ferr_q | ~serial_s,
                          par_en_q & parity_err_f(shift_q, par_val_q, par_even_q),
                          shift_q};

    // Receive FSM: start detection, mid-bit sampling and frame assembly.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= S_IDLE;
            timer_q    <= DIVIDER_WIDTH'(0);
            div_q      <= DIVIDER_WIDTH'(2);
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            two_stop_q <= 1'b0;
            bit_cnt_q  <= 4'd0;
            stop_cnt_q <= 1'b0;
            ferr_q     <= 1'b0;
            par_val_q  <= 1'b0;
            shift_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!serial_s) begin
                        div_q      <= div_eff_s;
                        par_en_q   <= parity_bit_i;
                        par_even_q <= parity_even_i;
                        two_stop_q <= two_stop_bits_i;
                        timer_q    <= DIVIDER_WIDTH'(0);
                        state_q    <= S_START;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_START: begin
                    if (mid_s) begin
                        timer_q   <= DIVIDER_WIDTH'(0);
                        bit_cnt_q <= 4'd0;
                        state_q   <= serial_s ? S_IDLE : S_DATA;
                    end else begin
                        timer_q <= timer_q + DIVIDER_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (tick_s) begin
                        timer_q <= DIVIDER_WIDTH'(0);
                        shift_q <= {serial_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            stop_cnt_q <= 1'b0;
                            ferr_q     <= 1'b0;
                            state_q    <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        timer_q <= timer_q + DIVIDER_WIDTH'(1);
                    end
                end
                S_PARITY: begin
                    if (tick_s) begin
                        timer_q   <= DIVIDER_WIDTH'(0);
                        par_val_q <= serial_s;
                        state_q   <= S_STOP;
                    end else begin
                        timer_q <= timer_q + DIVIDER_WIDTH'(1);
                    end
                end
                S_STOP: begin
                    if (tick_s) begin
                        timer_q <= DIVIDER_WIDTH'(0);
                        if (last_stop_s) begin
                            // Entry is pushed this cycle (push_s); rearm at once.
                            state_q <= S_IDLE;
                        end else begin
                            stop_cnt_q <= 1'b1;
                            ferr_q     <= ~serial_s;
                        end
                    end else begin
                        timer_q <= timer_q + DIVIDER_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO state
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          ovr_q, ovr_d;
    logic          do_pop_s;
    logic          do_push_s;
    logic          full_s;
    logic          ovr_set_s;

    // FIFO next-state: push/pop arbitration, occupancy and sticky overrun.
    always_comb begin
        full_s    = (count_q == CW'(FIFO_DEPTH));
        do_pop_s  = bus.pop_i && (count_q != CW'(0));
        do_push_s = push_s && (!full_s || do_pop_s);
        ovr_set_s = push_s && full_s && !do_pop_s;

        wr_ptr_d = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        if (do_push_s && !do_pop_s) begin
            count_d = count_q + CW'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
        ready_d = (count_d != CW'(0));

        if (ovr_set_s) begin
            ovr_d = 1'b1;
        end else if (bus.clear_overrun_i) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // FIFO registers; storage is cleared on reset so outputs read 0.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
            ready_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= entry_s;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            ovr_q    <= ovr_d;
        end
    end

    logic [EW-1:0] head_s;
    assign head_s              = mem_q[rd_ptr_q];
    assign bus.data_o          = head_s[DATA_BITS-1:0];
    assign bus.parity_error_o  = head_s[DATA_BITS];
    assign bus.framing_error_o = head_s[DATA_BITS+1];
    assign bus.ready_o         = ready_q;
    assign bus.count_o         = count_q;
    assign bus.overrun_o       = ovr_q;
endmodule
